// File: rtl/s2p_frame_ctrl.sv
// Serial-to-parallel frame sequencer: drives the 5-to-32 bit-select and assembles 32-bit words.
// Word is valid one cycle after its 32nd bit; while a word waits for i_pready, o_srdy is low.
module s2p_frame_ctrl #(
  parameter int MSB_FIRST = 0,
  parameter int TIMEOUT   = 64,
  parameter int CNT_W     = 16
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_sstart,
  input  logic             i_svalid,
  input  logic             i_sdin,
  output logic             o_srdy,
  output logic [31:0]      o_pdata,
  output logic             o_pvalid,
  input  logic             i_pready,
  output logic [4:0]       o_sel,
  output logic [31:0]      o_bit_we,
  output logic             o_err_abort,
  output logic             o_err_timeout,
  output logic [CNT_W-1:0] o_frame_cnt
);

  localparam int TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_HOLD} state_t;

  state_t           r_state, w_state_nxt;
  logic [4:0]       r_cnt;
  logic [31:0]      r_shadow;
  logic [31:0]      r_pdata;
  logic             r_pvalid;
  logic             r_err_abort;
  logic             r_err_timeout;
  logic [CNT_W-1:0] r_frame_cnt;
  logic [TW-1:0]    r_tmo;

  logic             w_start;
  logic             w_acc;
  logic             w_last;
  logic             w_tmo_hit;
  logic [4:0]       w_idx;
  logic [31:0]      w_merged;

  assign o_srdy    = (r_state != ST_HOLD);
  assign w_start   = i_svalid & i_sstart & o_srdy;
  // In IDLE only a start bit is taken; anything else is silently dropped.
  assign w_acc     = i_svalid & o_srdy & (i_sstart | (r_state == ST_SHIFT));
  assign w_last    = w_acc & ~i_sstart & (r_state == ST_SHIFT) & (r_cnt == 5'd31);
  assign w_tmo_hit = (TIMEOUT != 0) & (r_state == ST_SHIFT) & ~w_acc & (r_tmo == TMO_LAST);

  // A start bit always lands at index 0, even when it aborts a frame mid-word.
  assign w_idx    = w_start ? 5'd0 : r_cnt;
  assign o_sel    = (MSB_FIRST != 0) ? (5'd31 - w_idx) : w_idx;
  assign o_bit_we = w_acc ? (32'd1 << o_sel) : 32'd0;

  always_comb begin
    w_merged        = w_start ? 32'd0 : r_shadow;
    w_merged[o_sel] = i_sdin;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (w_start) w_state_nxt = ST_SHIFT;
      ST_SHIFT: begin
        if (w_last)         w_state_nxt = ST_HOLD;
        else if (w_tmo_hit) w_state_nxt = ST_IDLE;
      end
      ST_HOLD:  if (r_pvalid && i_pready) w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_pdata       <= '0;
      r_pvalid      <= 1'b0;
      r_err_abort   <= 1'b0;
      r_err_timeout <= 1'b0;
      r_frame_cnt   <= '0;
      r_tmo         <= '0;
    end else begin
      r_err_abort   <= w_start & (r_state == ST_SHIFT);
      r_err_timeout <= w_tmo_hit;
      if (w_acc) begin
        r_tmo <= '0;
        if (w_last) begin
          r_shadow <= '0;
          r_cnt    <= '0;
          r_pdata  <= w_merged;
          r_pvalid <= 1'b1;
        end else begin
          r_shadow <= w_merged;
          r_cnt    <= w_start ? 5'd1 : r_cnt + 5'd1;
        end
      end else if (r_state == ST_SHIFT) begin
        if (w_tmo_hit) begin
          r_shadow <= '0;
          r_cnt    <= '0;
          r_tmo    <= '0;
        end else begin
          r_tmo <= r_tmo + TW'(1);
        end
      end else if ((r_state == ST_HOLD) && r_pvalid && i_pready) begin
        r_pvalid    <= 1'b0;
        r_frame_cnt <= r_frame_cnt + CNT_W'(1);
      end
    end
  end

  assign o_pdata       = r_pdata;
  assign o_pvalid      = r_pvalid;
  assign o_err_abort   = r_err_abort;
  assign o_err_timeout = r_err_timeout;
  assign o_frame_cnt   = r_frame_cnt;

endmodule

// File: tb/tb_s2p_frame_ctrl.sv
// Bench for s2p_frame_ctrl: LSB-first and MSB-first instances share one stimulus stream;
// expected words are queued at issue time and popped by a monitor at each handshake.
module tb_s2p_frame_ctrl;
  logic clk    = 1'b0;
  logic rst_n  = 1'b1;
  logic sstart = 1'b0;
  logic svalid = 1'b0;
  logic sdin   = 1'b0;
  logic pready = 1'b0;

  logic        srdy0, srdy1, pvalid0, pvalid1, abort0, abort1, tmo0, tmo1;
  logic [31:0] pdata0, pdata1, we0, we1;
  logic [4:0]  sel0, sel1;
  logic [15:0] fc0, fc1;

  int          n_chk  = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  logic [15:0] exp_fc = 16'd0;

  always #5 clk = ~clk;

  s2p_frame_ctrl #(.MSB_FIRST(0), .TIMEOUT(64), .CNT_W(16)) u_lsb (
    .i_clk(clk), .i_rst_n(rst_n), .i_sstart(sstart), .i_svalid(svalid), .i_sdin(sdin),
    .o_srdy(srdy0), .o_pdata(pdata0), .o_pvalid(pvalid0), .i_pready(pready),
    .o_sel(sel0), .o_bit_we(we0), .o_err_abort(abort0), .o_err_timeout(tmo0),
    .o_frame_cnt(fc0)
  );

  s2p_frame_ctrl #(.MSB_FIRST(1), .TIMEOUT(64), .CNT_W(16)) u_msb (
    .i_clk(clk), .i_rst_n(rst_n), .i_sstart(sstart), .i_svalid(svalid), .i_sdin(sdin),
    .o_srdy(srdy1), .o_pdata(pdata1), .o_pvalid(pvalid1), .i_pready(pready),
    .o_sel(sel1), .o_bit_we(we1), .o_err_abort(abort1), .o_err_timeout(tmo1),
    .o_frame_cnt(fc1)
  );

  function automatic logic [31:0] rev32(input logic [31:0] w);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) r[i] = w[31 - i];
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard monitor: every handshake must present the oldest queued word.
  always @(negedge clk) begin
    if (rst_n && pvalid0 && pready) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_word: got %h, expected no word (t=%0t)", pdata0, $time);
      end else begin
        logic [31:0] w;
        w = exp_q.pop_front();
        chk("pdata", {pdata0, pdata1}, {w, rev32(w)});
        chk("pvalid_pair", 64'({pvalid0, pvalid1}), 64'(2'b11));
      end
    end
  end

  task automatic reset_chk(input string tag);
    chk({tag, "_vld_err"}, 64'({pvalid0, pvalid1, abort0, abort1, tmo0, tmo1}), 64'd0);
    chk({tag, "_pdata"}, {pdata0, pdata1}, 64'd0);
    chk({tag, "_fcnt"}, 64'({fc0, fc1}), 64'd0);
    chk({tag, "_sel"}, 64'({sel0, sel1}), 64'({5'd0, 5'd31}));
    chk({tag, "_srdy_we"}, 64'({srdy0, srdy1, we0 | we1}), 64'({2'b11, 32'd0}));
  endtask

  // Sends n bits of w (bit 0 first, SSTART on the first); abort_at1 expects ERR_ABORT on the next cycle.
  task automatic send_bits(input logic [31:0] w, input int n, input logic abort_at1);
    logic [31:0] e0, e1;
    logic [4:0]  s0, s1;
    for (int i = 0; i < n; i++) begin
      svalid = 1'b1;
      sstart = (i == 0);
      sdin   = w[i];
      @(negedge clk);
      e0 = 32'd1 << i;
      e1 = 32'd1 << (31 - i);
      s0 = i[4:0];
      s1 = 5'(31 - i);
      chk("bit_we", {we0, we1}, {e0, e1});
      chk("sel", 64'({sel0, sel1}), 64'({s0, s1}));
      chk("err_abort", 64'({abort0, abort1}), 64'({2{abort_at1 && (i == 1)}}));
      chk("srdy_pvalid", 64'({srdy0, srdy1, pvalid0, pvalid1}), 64'(4'b1100));
      tick();
    end
    svalid = 1'b0;
    sstart = 1'b0;
  endtask

  task automatic send_frame(input logic [31:0] w, input logic abort_at1);
    exp_q.push_back(w);
    send_bits(w, 32, abort_at1);
    chk("pvalid_latency", 64'({pvalid0, pvalid1}), 64'(2'b11));
    chk("fcnt_at_done", 64'({fc0, fc1}), 64'({exp_fc, exp_fc}));
  endtask

  task automatic handshake();
    pready = 1'b1;
    tick();
    pready = 1'b0;
    exp_fc++;
    chk("pvalid_clr", 64'({pvalid0, pvalid1}), 64'd0);
    chk("frame_cnt", 64'({fc0, fc1}), 64'({exp_fc, exp_fc}));
  endtask

  initial begin
    #1 rst_n = 1'b0;
    #2 reset_chk("reset");
    #9 rst_n = 1'b1;
    tick();

    // Basic frame, checked against both bit orders.
    send_frame(32'hA5C3_0F1E, 1'b0);
    handshake();

    // Backpressure: serial activity during HOLD must not be absorbed.
    send_frame(32'h1234_5678, 1'b0);
    for (int k = 0; k < 10; k++) begin
      svalid = 1'b1;
      sstart = k[0];
      sdin   = ~sdin;
      @(negedge clk);
      chk("hold_srdy_we", 64'({srdy0, srdy1, we0 | we1}), 64'd0);
      chk("hold_pdata", {pdata0, pdata1}, {32'h1234_5678, rev32(32'h1234_5678)});
      chk("hold_pvalid", 64'({pvalid0, pvalid1}), 64'(2'b11));
      tick();
    end
    svalid = 1'b0;
    sstart = 1'b0;
    handshake();

    // Abort: 12 bits, then a restart with a full word of ones.
    send_bits(32'h0000_0ABC, 12, 1'b0);
    send_frame(32'hFFFF_FFFF, 1'b1);
    handshake();

    // Timeout after 5 bits and 64 idle cycles.
    send_bits(32'h0000_0016, 5, 1'b0);
    for (int k = 0; k < 64; k++) begin
      @(negedge clk);
      chk("tmo_early", 64'({tmo0, tmo1}), 64'd0);
      tick();
    end
    @(negedge clk);
    chk("tmo_pulse", 64'({tmo0, tmo1, pvalid0, pvalid1, srdy0, srdy1}), 64'(6'b110011));
    tick();
    chk("tmo_clear", 64'({tmo0, tmo1, abort0, abort1}), 64'd0);
    send_frame(32'hC001_D00D, 1'b0);
    handshake();

    // Asynchronous reset at bit 20.
    send_bits(32'hFFFF_0000, 20, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_chk("rst_mid");
    #3 rst_n = 1'b1;
    exp_fc = 16'd0;
    tick();
    for (int k = 0; k < 3; k++) begin
      svalid = 1'b1;
      sstart = 1'b0;
      sdin   = 1'b1;
      @(negedge clk);
      chk("drop_we", 64'({we0, we1}), 64'd0);
      tick();
    end
    svalid = 1'b0;
    send_frame(32'h8000_0001, 1'b0);
    handshake();

    // Asynchronous reset while a word is held.
    send_frame(32'h5A5A_A5A5, 1'b0);
    #2 rst_n = 1'b0;
    #1 reset_chk("rst_hold");
    exp_q.delete();
    exp_fc = 16'd0;
    #3 rst_n = 1'b1;
    tick();
    send_frame(32'h0F0F_3C3C, 1'b0);
    handshake();

    tick();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    n_chk++;
    n_fail++;
    $display("FAIL watchdog: simulation time limit reached before end of sequence");
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/s2p_frame_ctrl.md
Name: s2p_frame_ctrl

Overview:
Sequencing controller for the serial-to-parallel interface. It accepts a framed serial bitstream and drives the 5-bit bit-select into the 5-to-32 one-hot decode. It assembles 32-bit words from the decoded write strobes and presents each word on a valid/ready parallel port. It also handles backpressure, frame abort and inter-bit timeout.

Parameters:
MSB_FIRST, 0, 0: first serial bit lands in PDATA[0]; 1: first serial bit lands in PDATA[31] (SEL = 31 - count)
TIMEOUT, 64, cycles allowed in SHIFT without an accepted bit before the frame is dropped; 0 disables the timeout
CNT_W, 16, width of FRAME_CNT

Ports:
CLK  input  1  rising-edge clock
RST_N  input  1  asynchronous active-low reset
SSTART  input  1  marks the first bit of a frame; qualified by SVALID
SVALID  input  1  serial bit valid
SDIN  input  1  serial data bit
SRDY  output  1  controller can accept a serial bit
PDATA  output  32  assembled parallel word
PVALID  output  1  PDATA holds a complete word
PREADY  input  1  downstream accepts the word
SEL  output  5  current bit-select index into the decode
BIT_WE  output  32  one-hot write strobe = decode(SEL) & accepted bit
ERR_ABORT  output  1  one-cycle pulse: frame restarted mid-word
ERR_TIMEOUT  output  1  one-cycle pulse: frame dropped on timeout
FRAME_CNT  output  CNT_W  count of completed handshakes; wraps

Behaviour:
- Clock and reset: single clock CLK; RST_N is asynchronous, active-low. While RST_N=0: state=IDLE, bit count=0, shadow=0, PDATA=0, PVALID=0, ERR_*=0, FRAME_CNT=0, timeout counter=0.
- SRDY = (state != HOLD). Combinational, no dependence on PREADY.
- A bit is accepted when SVALID & SRDY, subject to the per-state rules below.
- SEL: equals count when MSB_FIRST=0, and 31 - count when MSB_FIRST=1. Combinational from the count register. Equals 0 (or 31) in IDLE.
- BIT_WE: one-hot decode of SEL, gated by acceptance. All-zero when no bit is accepted. Exactly one bit is set on acceptance.
- IDLE state:
  - SVALID & SSTART: accept the bit as index 0, go to SHIFT, count=1.
  - SVALID without SSTART: bit dropped, no error, stay in IDLE.
- SHIFT state:
  - Accepted bit: shadow[SEL] <= SDIN, count += 1, timeout counter cleared.
  - SSTART & SVALID: ERR_ABORT pulses. Shadow is cleared, the current bit is written as index 0, count=1, state stays SHIFT.
  - Accepted bit with count=31 (SSTART=0):
    - PDATA <= shadow with the final bit merged.
    - PVALID <= 1, FRAME_CNT unchanged, count <= 0, state goes to HOLD.
    - PVALID is visible the cycle after the 32nd bit is accepted.
  - No accepted bit: timeout counter += 1.
  - Timeout counter reaching TIMEOUT (TIMEOUT != 0): ERR_TIMEOUT pulses for one cycle, go to IDLE. Shadow and count are cleared; PDATA is unchanged.
- HOLD state:
  - SRDY=0, so all serial input is ignored, including SSTART.
  - PDATA and PVALID are held stable.
  - PVALID & PREADY: PVALID <= 0, FRAME_CNT += 1 (wraps at 2^CNT_W), go to IDLE.
  - The earliest next-frame bit is accepted the cycle after the handshake.
- Shadow/PDATA separation: PDATA changes only on the completion edge. Partial frames are never visible on PDATA.
- ERR_ABORT and ERR_TIMEOUT cannot assert in the same cycle: an accepted bit clears the timeout.
- Reset mid-frame or mid-HOLD: the reset values above apply immediately (asynchronously). The partial word or held word is lost.
- PREADY is ignored while PVALID=0.

Test Plan:
- Reset, then 32 accepted bits of 0xA5C3_0F1E, LSB first, MSB_FIRST=0, SSTART on bit 0 -> BIT_WE walks 0x1..0x8000_0000. PVALID=1 one cycle after bit 31 with PDATA=0xA5C3_0F1E; PREADY=1 -> FRAME_CNT=1, back to IDLE.
- MSB_FIRST=1, same stream -> SEL walks 31 down to 0 and PDATA equals the bit-reverse of the word.
- Complete a frame with PREADY=0 for 10 cycles while SVALID/SSTART keep toggling -> SRDY=0 and PDATA is stable for all 10 cycles. No bits are absorbed; the handshake then completes.
- Send 12 bits, then SSTART with a new frame of 32 bits of 0xFFFF_FFFF -> single-cycle ERR_ABORT, PDATA=0xFFFF_FFFF, FRAME_CNT increments by 1 only.
- TIMEOUT=64: send 5 bits, then idle 64 cycles -> ERR_TIMEOUT one-cycle pulse, state IDLE, PVALID stays 0. Next full frame decodes correctly from index 0.
- Assert RST_N=0 asynchronously at bit 20 and again while PVALID=1 -> all outputs return to reset values before the next edge. SVALID without SSTART after reset is dropped.
